// File: rtl/run_ctrl.sv
// run_ctrl: single-step / run / halt controller producing a processor clock-enable.
// Ports: Clk, Reset (sync, active-high), StepBtn, RunBtn (raw async buttons),
//        Halt (processor halted level), CpuEn (one-cycle enable pulse),
//        Running, Halted (state flags), InstrCount (saturating CpuEn count).
// Option: define RUN_CTRL_DEBOUNCE_EN to insert a DB_CYCLES debouncer per button.
module run_ctrl #(
    parameter int DB_CYCLES = 16,
    parameter int RUN_DIV   = 4,
    parameter int CNT_W     = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             StepBtn,
    input  logic             RunBtn,
    input  logic             Halt,
    output logic             CpuEn,
    output logic             Running,
    output logic             Halted,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [1:0] S_PAUSE  = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    localparam logic [7:0]       DIV_LAST = 8'(RUN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    generate
        if (RUN_DIV < 2 || RUN_DIV > 255 || DB_CYCLES < 1) begin : g_bad_param
            $error("run_ctrl: illegal parameter value");
        end
    endgenerate

    // Synchronizers reset high so a button held through reset looks
    // already-pressed and cannot fire until released and pressed again.
    logic [1:0] step_sync;
    logic [1:0] run_sync;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            step_sync <= 2'b11;
            run_sync  <= 2'b11;
        end else begin
            step_sync <= {step_sync[0], StepBtn};
            run_sync  <= {run_sync[0], RunBtn};
        end
    end

    logic step_lvl;
    logic run_lvl;

`ifdef RUN_CTRL_DEBOUNCE_EN
    localparam int             DBW     = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [DBW-1:0] DB_ONE  = 1;

    logic           step_db;
    logic           run_db;
    logic [DBW-1:0] step_cnt;
    logic [DBW-1:0] run_cnt;

    // Output follows the input only after DB_CYCLES consecutive samples
    // that disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            step_db  <= 1'b1;
            run_db   <= 1'b1;
            step_cnt <= '0;
            run_cnt  <= '0;
        end else begin
            if (step_sync[1] == step_db) begin
                step_cnt <= '0;
            end else if (step_cnt == DB_LAST) begin
                step_db  <= step_sync[1];
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + DB_ONE;
            end
            if (run_sync[1] == run_db) begin
                run_cnt <= '0;
            end else if (run_cnt == DB_LAST) begin
                run_db  <= run_sync[1];
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + DB_ONE;
            end
        end
    end

    assign step_lvl = step_db;
    assign run_lvl  = run_db;
`else
    assign step_lvl = step_sync[1];
    assign run_lvl  = run_sync[1];
`endif

    logic step_prev;
    logic run_prev;
    logic step_p;
    logic run_p;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            step_prev <= 1'b1;
            run_prev  <= 1'b1;
        end else begin
            step_prev <= step_lvl;
            run_prev  <= run_lvl;
        end
    end

    assign step_p = step_lvl & ~step_prev;
    assign run_p  = run_lvl & ~run_prev;

    logic [1:0] state;
    logic [1:0] nxt_state;
    logic [7:0] div;
    logic [7:0] nxt_div;
    logic       nxt_en;

    // Halt dominates everything; in RUN the enable fires on the edge
    // that sees the divider at its terminal count.
    always_comb begin
        nxt_state = state;
        nxt_div   = div;
        nxt_en    = 1'b0;
        if (Halt) begin
            nxt_state = S_HALTED;
            nxt_div   = '0;
        end else begin
            unique case (state)
                S_PAUSE: begin
                    if (run_p) begin
                        nxt_state = S_RUN;
                        nxt_div   = '0;
                    end else if (step_p) begin
                        nxt_en = 1'b1;
                    end
                end
                S_RUN: begin
                    if (run_p) begin
                        nxt_state = S_PAUSE;
                        nxt_div   = '0;
                    end else if (div == DIV_LAST) begin
                        nxt_div = '0;
                        nxt_en  = 1'b1;
                    end else begin
                        nxt_div = div + 8'd1;
                    end
                end
                S_HALTED: begin
                    if (run_p) begin
                        nxt_state = S_PAUSE;
                    end
                end
                default: begin
                    nxt_state = S_PAUSE;
                    nxt_div   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_PAUSE;
            div        <= '0;
            CpuEn      <= 1'b0;
            Running    <= 1'b0;
            Halted     <= 1'b0;
            InstrCount <= '0;
        end else begin
            state   <= nxt_state;
            div     <= nxt_div;
            CpuEn   <= nxt_en;
            Running <= (nxt_state == S_RUN);
            Halted  <= (nxt_state == S_HALTED);
            if (nxt_en && (InstrCount != '1)) begin
                InstrCount <= InstrCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl.
// DUT built with RUN_DIV=4, CNT_W=4, DB_CYCLES=16.
module tb_run_ctrl;

`ifdef RUN_CTRL_DEBOUNCE_EN
    localparam int LAT = 19;
`else
    localparam int LAT = 3;
`endif
    localparam int GAP = LAT + 3;

    logic       Clk     = 1'b0;
    logic       Reset   = 1'b1;
    logic       StepBtn = 1'b0;
    logic       RunBtn  = 1'b0;
    logic       Halt    = 1'b0;
    logic       CpuEn;
    logic       Running;
    logic       Halted;
    logic [3:0] InstrCount;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    logic prev_en  = 1'b0;

    run_ctrl #(
        .DB_CYCLES(16),
        .RUN_DIV  (4),
        .CNT_W    (4)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .StepBtn   (StepBtn),
        .RunBtn    (RunBtn),
        .Halt      (Halt),
        .CpuEn     (CpuEn),
        .Running   (Running),
        .Halted    (Halted),
        .InstrCount(InstrCount)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        n_checks++;
        if (prev_en === 1'b1 && CpuEn === 1'b1) begin
            n_fail++;
            $display("FAIL cpuen_consecutive: got 1 after 1, want 0");
        end
        prev_en = CpuEn;
    end

    function automatic int sat(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Hold the chosen buttons for 'hold' cycles, then idle for 'gap' cycles,
    // counting CpuEn pulses and the cycle index of the first one.
    task automatic drive(input bit s, input bit r, input int hold,
                         input int gap, output int np, output int first);
        np    = 0;
        first = -1;
        StepBtn = s;
        RunBtn  = r;
        for (int i = 1; i <= hold + gap; i++) begin
            tick();
            if (i == hold) begin
                StepBtn = 1'b0;
                RunBtn  = 1'b0;
            end
            if (CpuEn === 1'b1) begin
                np++;
                if (first < 0) first = i;
            end
        end
        StepBtn = 1'b0;
        RunBtn  = 1'b0;
    endtask

    // Press RunBtn from PAUSE and return the cycle index of the first CpuEn.
    task automatic enter_run(output int p);
        p = -1;
        RunBtn = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == LAT + 2) RunBtn = 1'b0;
            if (CpuEn === 1'b1) begin
                p = i;
                break;
            end
        end
        RunBtn = 1'b0;
    endtask

    task automatic test_reset();
        int np, first;
        Reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (CpuEn !== 1'b0) begin
            n_fail++; $display("FAIL reset_cpuen: got %b want 0", CpuEn);
        end
        n_checks++;
        if (Running !== 1'b0) begin
            n_fail++; $display("FAIL reset_running: got %b want 0", Running);
        end
        n_checks++;
        if (Halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_halted: got %b want 0", Halted);
        end
        n_checks++;
        if (InstrCount !== 4'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", InstrCount);
        end
        Reset = 1'b0;
        drive(1'b0, 1'b0, 0, GAP, np, first);
        n_checks++;
        if (np != 0) begin
            n_fail++; $display("FAIL reset_idle_pulses: got %0d want 0", np);
        end
        exp_cnt = 0;
    endtask

    task automatic test_step();
        int np, first;
        drive(1'b1, 1'b0, LAT + 2, GAP, np, first);
        exp_cnt = sat(exp_cnt + 1);
        n_checks++;
        if (np != 1) begin
            n_fail++; $display("FAIL step_pulses: got %0d want 1", np);
        end
        n_checks++;
        if (first != LAT) begin
            n_fail++; $display("FAIL step_latency: got %0d want %0d", first, LAT);
        end
        n_checks++;
        if (InstrCount !== 4'(exp_cnt)) begin
            n_fail++; $display("FAIL step_count: got %0d want %0d", InstrCount, exp_cnt);
        end
        n_checks++;
        if (Running !== 1'b0) begin
            n_fail++; $display("FAIL step_running: got %b want 0", Running);
        end
    endtask

    task automatic test_run();
        int np, first, run_at, bad, pause_at, late;
        np = 0; first = -1; run_at = -1; bad = 0;
        RunBtn = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (Running === 1'b1 && run_at < 0) run_at = i;
            if (CpuEn === 1'b1) begin
                np++;
                if (first < 0) first = i;
                if (((i - LAT) % 4) != 0) bad++;
            end
        end
        RunBtn = 1'b0;
        exp_cnt = sat(exp_cnt + (50 - LAT) / 4);
        n_checks++;
        if (run_at != LAT) begin
            n_fail++; $display("FAIL run_entry: got %0d want %0d", run_at, LAT);
        end
        n_checks++;
        if (first != LAT + 4) begin
            n_fail++; $display("FAIL run_first: got %0d want %0d", first, LAT + 4);
        end
        n_checks++;
        if (np != (50 - LAT) / 4) begin
            n_fail++; $display("FAIL run_pulses: got %0d want %0d", np, (50 - LAT) / 4);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL run_period: got %0d off-grid want 0", bad);
        end
        n_checks++;
        if (InstrCount !== 4'(exp_cnt)) begin
            n_fail++; $display("FAIL run_count: got %0d want %0d", InstrCount, exp_cnt);
        end
        drive(1'b0, 1'b0, 0, GAP, np, first);
        exp_cnt = sat(exp_cnt + np);
        pause_at = -1; late = 0;
        RunBtn = 1'b1;
        for (int i = 1; i <= LAT + 2 + GAP; i++) begin
            tick();
            if (i == LAT + 2) RunBtn = 1'b0;
            if (Running === 1'b0 && pause_at < 0) pause_at = i;
            if (CpuEn === 1'b1) begin
                if (pause_at >= 0) late++;
                else exp_cnt = sat(exp_cnt + 1);
            end
        end
        n_checks++;
        if (pause_at != LAT) begin
            n_fail++; $display("FAIL run_pause_at: got %0d want %0d", pause_at, LAT);
        end
        n_checks++;
        if (late != 0) begin
            n_fail++; $display("FAIL run_pause_pulses: got %0d want 0", late);
        end
        n_checks++;
        if (InstrCount !== 4'(exp_cnt)) begin
            n_fail++; $display("FAIL run_pause_count: got %0d want %0d", InstrCount, exp_cnt);
        end
    endtask

    task automatic test_halt();
        int p, np, first;
        enter_run(p);
        n_checks++;
        if (p < 0) begin
            n_fail++; $display("FAIL halt_run_pulse: got none want a pulse");
        end else begin
            repeat (3) tick();
            Halt = 1'b1;
            tick();
            n_checks++;
            if (CpuEn !== 1'b0) begin
                n_fail++; $display("FAIL halt_cpuen: got %b want 0", CpuEn);
            end
            n_checks++;
            if (Halted !== 1'b1) begin
                n_fail++; $display("FAIL halt_halted: got %b want 1", Halted);
            end
            n_checks++;
            if (Running !== 1'b0) begin
                n_fail++; $display("FAIL halt_running: got %b want 0", Running);
            end
            drive(1'b0, 1'b0, 0, GAP, np, first);
            drive(1'b0, 1'b1, LAT + 2, GAP, np, first);
            n_checks++;
            if (Halted !== 1'b1) begin
                n_fail++; $display("FAIL halt_run_ignored: got %b want 1", Halted);
            end
            n_checks++;
            if (np != 0) begin
                n_fail++; $display("FAIL halt_pulses: got %0d want 0", np);
            end
            Halt = 1'b0;
            tick();
            n_checks++;
            if (Halted !== 1'b1) begin
                n_fail++; $display("FAIL halt_hold: got %b want 1", Halted);
            end
            drive(1'b0, 1'b1, LAT + 2, GAP, np, first);
            n_checks++;
            if (Halted !== 1'b0 || Running !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_exit: got halted=%b running=%b want 0 0", Halted, Running);
            end
        end
    endtask

    task automatic test_reset_abort();
        int p, np, first;
        enter_run(p);
        n_checks++;
        if (p < 0) begin
            n_fail++; $display("FAIL abort_run_pulse: got none want a pulse");
        end else begin
            repeat (3) tick();
            Reset = 1'b1;
            tick();
            Reset = 1'b0;
            n_checks++;
            if (CpuEn !== 1'b0) begin
                n_fail++; $display("FAIL abort_cpuen: got %b want 0", CpuEn);
            end
            n_checks++;
            if (Running !== 1'b0) begin
                n_fail++; $display("FAIL abort_running: got %b want 0", Running);
            end
            n_checks++;
            if (InstrCount !== 4'd0) begin
                n_fail++; $display("FAIL abort_count: got %0d want 0", InstrCount);
            end
            drive(1'b0, 1'b0, 0, GAP, np, first);
            n_checks++;
            if (np != 0) begin
                n_fail++; $display("FAIL abort_pulses: got %0d want 0", np);
            end
        end
        exp_cnt = 0;
    endtask

    task automatic test_step_run_same_cycle();
        int np, run_at;
        np = 0; run_at = -1;
        StepBtn = 1'b1;
        RunBtn  = 1'b1;
        for (int i = 1; i <= LAT + 3; i++) begin
            tick();
            if (i == LAT + 2) begin
                StepBtn = 1'b0;
                RunBtn  = 1'b0;
            end
            if (Running === 1'b1 && run_at < 0) run_at = i;
            if (CpuEn === 1'b1) np++;
        end
        n_checks++;
        if (run_at != LAT) begin
            n_fail++; $display("FAIL both_run_entry: got %0d want %0d", run_at, LAT);
        end
        n_checks++;
        if (np != 0) begin
            n_fail++; $display("FAIL both_step_pulse: got %0d want 0", np);
        end
    endtask

    task automatic test_saturate();
        int np, first, tot;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        drive(1'b0, 1'b0, 0, GAP, np, first);
        tot = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b0, LAT + 2, GAP, np, first);
            tot += np;
            if (k == 9) begin
                n_checks++;
                if (InstrCount !== 4'd10) begin
                    n_fail++; $display("FAIL sat_mid_count: got %0d want 10", InstrCount);
                end
            end
        end
        n_checks++;
        if (tot != 20) begin
            n_fail++; $display("FAIL sat_pulses: got %0d want 20", tot);
        end
        n_checks++;
        if (InstrCount !== 4'(sat(20))) begin
            n_fail++; $display("FAIL sat_count: got %0d want 15", InstrCount);
        end
    endtask

    task automatic test_debounce();
`ifdef RUN_CTRL_DEBOUNCE_EN
        int np, first;
        drive(1'b1, 1'b0, 10, GAP, np, first);
        n_checks++;
        if (np != 0) begin
            n_fail++; $display("FAIL db_glitch: got %0d pulses want 0", np);
        end
        drive(1'b1, 1'b0, 20, GAP, np, first);
        n_checks++;
        if (np != 1) begin
            n_fail++; $display("FAIL db_press_pulses: got %0d want 1", np);
        end
        n_checks++;
        if (first != 19) begin
            n_fail++; $display("FAIL db_press_latency: got %0d want 19", first);
        end
`endif
    endtask

    task automatic test_reset_hold();
        int np, np2, first;
        np = 0;
        StepBtn = 1'b1;
        Reset   = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (CpuEn === 1'b1) np++;
        end
        StepBtn = 1'b0;
        drive(1'b0, 1'b0, 0, GAP, np2, first);
        np += np2;
        n_checks++;
        if (np != 0) begin
            n_fail++; $display("FAIL hold_reset_pulses: got %0d want 0", np);
        end
        drive(1'b1, 1'b0, LAT + 2, GAP, np, first);
        n_checks++;
        if (np != 1) begin
            n_fail++; $display("FAIL hold_repress_pulses: got %0d want 1", np);
        end
        n_checks++;
        if (first != LAT) begin
            n_fail++; $display("FAIL hold_repress_latency: got %0d want %0d", first, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run();
        test_halt();
        test_reset_abort();
        test_step_run_same_cycle();
        test_saturate();
        test_debounce();
        test_reset_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
